// File: rtl/cordic_freq_disc.sv
// Frequency discriminator behind a serial magnitude/phase CORDIC: differentiates
// successive phases, squelches weak samples and averages 2^AVG_LOG2 increments.
module cordic_freq_disc #(
  parameter int XY_WIDTH = 14,
  parameter int AVG_LOG2 = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                mag_rdy,
  input  logic [XY_WIDTH-1:0] mag,
  input  logic [XY_WIDTH+1:0] ph,
  input  logic [XY_WIDTH-1:0] thr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XY_WIDTH+1:0] freq,
  output logic                sq,
  output logic                ovf
);
  localparam int W  = XY_WIDTH + 2;
  localparam int AW = W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic signed [W:0] PI     = (W+1)'(2**(W-2));
  localparam logic signed [W:0] TWO_PI = (W+1)'(2**(W-1));
  localparam logic [CW-1:0]     CNT_LAST = CW'(2**AVG_LOG2 - 1);

  typedef enum logic {NOPREV, RUN} state_t;

  state_t                state_q, state_d;
  logic                  mag_rdy_q, mag_rdy_d;
  logic                  s1_vld_q, s1_vld_d;
  logic signed [W-1:0]   s1_ph_q, s1_ph_d;
  logic [XY_WIDTH-1:0]   s1_mag_q, s1_mag_d;
  logic signed [W-1:0]   prev_ph_q, prev_ph_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          freq_q, freq_d;
  logic                  sq_q, sq_d;
  logic                  ovf_q, ovf_d;

  logic                  capture;
  logic signed [W:0]     d_raw, d_wrap;
  logic signed [W-1:0]   d_w;
  logic signed [AW-1:0]  d_ext, sum;
  logic [W-1:0]          res_val;
  logic                  res_vld;

  // Rising-edge detect on mag_rdy; the history flop keeps tracking even under clr.
  always_comb begin
    mag_rdy_d = mag_rdy;
    capture   = mag_rdy & ~mag_rdy_q;
    s1_vld_d  = capture & ~clr;
    s1_ph_d   = capture ? ph  : s1_ph_q;
    s1_mag_d  = capture ? mag : s1_mag_q;
  end

  // Phase increment wrapped into (-pi, pi]; fits W bits once wrapped.
  always_comb begin
    d_raw  = (W+1)'(s1_ph_q) - (W+1)'(prev_ph_q);
    d_wrap = d_raw;
    if (d_raw > PI)
      d_wrap = d_raw - TWO_PI;
    else if (d_raw <= -PI)
      d_wrap = d_raw + TWO_PI;
    d_w     = W'(d_wrap);
    d_ext   = AW'(d_w);
    sum     = acc_q + d_ext;
    res_val = W'(sum >>> AVG_LOG2);
  end

  always_comb begin
    state_d     = state_q;
    prev_ph_d   = prev_ph_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;
    res_vld     = 1'b0;
    out_valid_d = out_valid_q;
    freq_d      = freq_q;
    ovf_d       = ovf_q;

    if (s1_vld_q) begin
      if (s1_mag_q < thr) begin
        sq_d    = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = NOPREV;
      end else begin
        sq_d      = 1'b0;
        prev_ph_d = s1_ph_q;
        if (state_q == NOPREV) begin
          state_d = RUN;
        end else if (cnt_q == CNT_LAST) begin
          res_vld = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // A result arriving while the held one is unconsumed is dropped, not queued.
    if (res_vld) begin
      if (!out_valid_q || out_ready) begin
        freq_d      = res_val;
        out_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      state_d     = NOPREV;
      prev_ph_d   = prev_ph_q;
      acc_d       = '0;
      cnt_d       = '0;
      sq_d        = 1'b0;
      out_valid_d = 1'b0;
      freq_d      = freq_q;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NOPREV;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_rdy_q   <= 1'b1;
      s1_vld_q    <= 1'b0;
      s1_ph_q     <= '0;
      s1_mag_q    <= '0;
      prev_ph_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      freq_q      <= '0;
      sq_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      mag_rdy_q   <= mag_rdy_d;
      s1_vld_q    <= s1_vld_d;
      s1_ph_q     <= s1_ph_d;
      s1_mag_q    <= s1_mag_d;
      prev_ph_q   <= prev_ph_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      freq_q      <= freq_d;
      sq_q        <= sq_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign freq      = freq_q;
  assign sq        = sq_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_freq_disc.sv
// Bench for cordic_freq_disc: AVG_LOG2=0 and AVG_LOG2=2 instances share stimulus,
// each checked against a per-sample arithmetic model.
module tb_cordic_freq_disc;
  localparam int XW = 14;
  localparam int W  = 16;
  localparam int PI = 'h4000;
  localparam logic [XW-1:0] THR    = 14'h0100;
  localparam logic [XW-1:0] MAG_OK = 14'h2000;
  localparam logic [XW-1:0] MAG_LO = 14'h0080;

  logic clk = 1'b0;
  logic reset, clr, mag_rdy, out_ready;
  logic [XW-1:0] mag, thr;
  logic [W-1:0]  ph;
  logic [1:0]    ov, sqo, ovo;
  logic [1:0][W-1:0] fr;
  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cordic_freq_disc #(.XY_WIDTH(XW), .AVG_LOG2(0)) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .mag_rdy(mag_rdy), .mag(mag), .ph(ph),
    .thr(thr), .out_valid(ov[0]), .out_ready(out_ready), .freq(fr[0]),
    .sq(sqo[0]), .ovf(ovo[0]));

  cordic_freq_disc #(.XY_WIDTH(XW), .AVG_LOG2(2)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .mag_rdy(mag_rdy), .mag(mag), .ph(ph),
    .thr(thr), .out_valid(ov[1]), .out_ready(out_ready), .freq(fr[1]),
    .sq(sqo[1]), .ovf(ovo[1]));

  // Reference model, one sample per call
  bit           m_has[2];
  int           m_prev[2];
  int           m_acc[2];
  int           m_cnt[2];
  bit           m_vld[2];
  bit           m_ovf[2];
  bit           m_sq[2];
  logic [W-1:0] m_freq[2];

  function automatic int avg_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic void m_reset(bit full);
    for (int i = 0; i < 2; i++) begin
      m_has[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
      m_vld[i] = 0; m_ovf[i] = 0; m_sq[i] = 0;
      if (full) begin m_prev[i] = 0; m_freq[i] = '0; end
    end
  endfunction

  function automatic void m_sample(logic [W-1:0] p, logic [XW-1:0] m, bit rb, bit rk);
    int d, res, n;
    bit got;
    for (int i = 0; i < 2; i++) begin
      if (rb) m_vld[i] = 0;
      got = 0; res = 0;
      n = 1 << avg_of(i);
      if (m < THR) begin
        m_sq[i] = 1; m_has[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
      end else begin
        m_sq[i] = 0;
        if (m_has[i]) begin
          d = int'($signed(p)) - m_prev[i];
          if (d > PI) d -= 2*PI;
          else if (d <= -PI) d += 2*PI;
          m_acc[i] += d;
          m_cnt[i]++;
          if (m_cnt[i] == n) begin
            res = m_acc[i] >>> avg_of(i);
            got = 1; m_acc[i] = 0; m_cnt[i] = 0;
          end
        end
        m_has[i] = 1;
        m_prev[i] = int'($signed(p));
      end
      if (got) begin
        if (!m_vld[i] || rk) begin m_vld[i] = 1; m_freq[i] = res[W-1:0]; end
        else m_ovf[i] = 1;
      end else if (rk) begin
        m_vld[i] = 0;
      end
    end
  endfunction

  // Idle edge + capture edge with out_ready=rb, processing edge with out_ready=rk
  task automatic send(input logic [W-1:0] p, input logic [XW-1:0] m, input bit rb, input bit rk);
    out_ready = rb;
    @(negedge clk); ph = p; mag = m; mag_rdy = 1'b1;
    @(negedge clk); mag_rdy = 1'b0; out_ready = rk;
    @(negedge clk);
    m_sample(p, m, rb, rk);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_reset(0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cmp_cnt++; if (ov[i] !== 1'b0)  begin err_cnt++; $display("FAIL reset out_valid[%0d] got %b want 0", i, ov[i]); end
      cmp_cnt++; if (fr[i] !== 16'h0) begin err_cnt++; $display("FAIL reset freq[%0d] got %h want 0000", i, fr[i]); end
      cmp_cnt++; if (sqo[i] !== 1'b0) begin err_cnt++; $display("FAIL reset sq[%0d] got %b want 0", i, sqo[i]); end
      cmp_cnt++; if (ovo[i] !== 1'b0) begin err_cnt++; $display("FAIL reset ovf[%0d] got %b want 0", i, ovo[i]); end
    end
    reset = 1'b0;
    m_reset(1);
  endtask

  task automatic test_basic();
    do_clr();
    send(16'h0000, MAG_OK, 1, 1);
    cmp_cnt++; if (ov[0] !== 1'b0) begin err_cnt++; $display("FAIL basic first out_valid got %b want 0", ov[0]); end
    send(16'h1000, MAG_OK, 1, 1);
    cmp_cnt++; if (ov[0] !== 1'b1) begin err_cnt++; $display("FAIL basic out_valid got %b want 1", ov[0]); end
    cmp_cnt++; if (fr[0] !== 16'h1000) begin err_cnt++; $display("FAIL basic freq got %h want 1000", fr[0]); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] tbl [3][3];
    tbl = '{'{16'h3000, 16'hD000, 16'h2000},
            '{16'h0000, 16'h4000, 16'h4000},
            '{16'h4000, 16'h0000, 16'h4000}};
    for (int t = 0; t < 3; t++) begin
      do_clr();
      send(tbl[t][0], MAG_OK, 1, 1);
      send(tbl[t][1], MAG_OK, 1, 1);
      cmp_cnt++; if (ov[0] !== 1'b1) begin err_cnt++; $display("FAIL wrap%0d out_valid got %b want 1", t, ov[0]); end
      cmp_cnt++; if (fr[0] !== tbl[t][2]) begin err_cnt++; $display("FAIL wrap%0d freq got %h want %h", t, fr[0], tbl[t][2]); end
    end
  endtask

  task automatic test_squelch();
    do_clr();
    send(16'h0000, MAG_OK, 1, 1);
    send(16'h0800, MAG_LO, 1, 1);
    cmp_cnt++; if (sqo !== 2'b11) begin err_cnt++; $display("FAIL squelch sq got %b want 11", sqo); end
    cmp_cnt++; if (ov[0] !== 1'b0) begin err_cnt++; $display("FAIL squelch out_valid got %b want 0", ov[0]); end
    send(16'h1000, MAG_OK, 1, 1);
    cmp_cnt++; if (ov[0] !== 1'b0) begin err_cnt++; $display("FAIL squelch ref out_valid got %b want 0", ov[0]); end
    cmp_cnt++; if (sqo[0] !== 1'b0) begin err_cnt++; $display("FAIL squelch sq clear got %b want 0", sqo[0]); end
    send(16'h1800, MAG_OK, 1, 1);
    cmp_cnt++; if (ov[0] !== 1'b1) begin err_cnt++; $display("FAIL squelch resume out_valid got %b want 1", ov[0]); end
    cmp_cnt++; if (fr[0] !== 16'h0800) begin err_cnt++; $display("FAIL squelch resume freq got %h want 0800", fr[0]); end
  endtask

  task automatic test_avg();
    logic [W-1:0] seq [2][5];
    logic [W-1:0] want [2];
    int n;
    seq  = '{'{16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0600},
             '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
    want = '{16'h0180, 16'hFFFF};
    for (int s = 0; s < 2; s++) begin
      do_clr();
      n = 0;
      for (int k = 0; k < 5; k++) begin
        send(seq[s][k], MAG_OK, 1, 1);
        if (ov[1]) n++;
      end
      cmp_cnt++; if (n != 1) begin err_cnt++; $display("FAIL avg%0d output count got %0d want 1", s, n); end
      cmp_cnt++; if (fr[1] !== want[s]) begin err_cnt++; $display("FAIL avg%0d freq got %h want %h", s, fr[1], want[s]); end
    end
  endtask

  task automatic test_backpressure();
    do_clr();
    send(16'h0000, MAG_OK, 0, 0);
    send(16'h0100, MAG_OK, 0, 0);
    send(16'h0300, MAG_OK, 0, 0);
    cmp_cnt++; if (ov[0] !== 1'b1) begin err_cnt++; $display("FAIL bp held out_valid got %b want 1", ov[0]); end
    cmp_cnt++; if (fr[0] !== 16'h0100) begin err_cnt++; $display("FAIL bp held freq got %h want 0100", fr[0]); end
    cmp_cnt++; if (ovo[0] !== 1'b1) begin err_cnt++; $display("FAIL bp ovf got %b want 1", ovo[0]); end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 2; i++) m_vld[i] = 0;
    cmp_cnt++; if (ov[0] !== 1'b0) begin err_cnt++; $display("FAIL bp drain out_valid got %b want 0", ov[0]); end
    cmp_cnt++; if (ovo[0] !== 1'b1) begin err_cnt++; $display("FAIL bp sticky ovf got %b want 1", ovo[0]); end
    do_clr();
    cmp_cnt++; if (ovo !== 2'b00) begin err_cnt++; $display("FAIL bp clr ovf got %b want 00", ovo); end
    send(16'h1000, MAG_OK, 1, 1);
    cmp_cnt++; if (ov[0] !== 1'b0) begin err_cnt++; $display("FAIL bp clr nopref out_valid got %b want 0", ov[0]); end
    send(16'h2000, MAG_OK, 0, 0);
    send(16'h2800, MAG_OK, 0, 1);
    cmp_cnt++; if (ov[0] !== 1'b1) begin err_cnt++; $display("FAIL bp replace out_valid got %b want 1", ov[0]); end
    cmp_cnt++; if (fr[0] !== 16'h0800) begin err_cnt++; $display("FAIL bp replace freq got %h want 0800", fr[0]); end
    cmp_cnt++; if (ovo[0] !== 1'b0) begin err_cnt++; $display("FAIL bp replace ovf got %b want 0", ovo[0]); end
  endtask

  task automatic test_reset_abort();
    send(16'h0000, MAG_OK, 1, 1);
    @(negedge clk); ph = 16'h1000; mag = MAG_OK; mag_rdy = 1'b1;
    @(negedge clk); mag_rdy = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_reset(1);
    @(negedge clk);
    cmp_cnt++; if (ov !== 2'b00) begin err_cnt++; $display("FAIL abort out_valid got %b want 00", ov); end
    cmp_cnt++; if (fr[0] !== 16'h0) begin err_cnt++; $display("FAIL abort freq got %h want 0000", fr[0]); end
    send(16'h2000, MAG_OK, 1, 1);
    cmp_cnt++; if (ov[0] !== 1'b0) begin err_cnt++; $display("FAIL abort nopref out_valid got %b want 0", ov[0]); end
  endtask

  task automatic test_level_hold();
    int n;
    do_clr();
    send(16'h0000, MAG_OK, 1, 1);
    @(negedge clk); out_ready = 1'b1; ph = 16'h0100; mag = MAG_OK; mag_rdy = 1'b1;
    n = 0;
    repeat (20) begin @(negedge clk); if (ov[0]) n++; end
    cmp_cnt++; if (n != 1) begin err_cnt++; $display("FAIL hold result count got %0d want 1", n); end
    cmp_cnt++; if (fr[0] !== 16'h0100) begin err_cnt++; $display("FAIL hold freq got %h want 0100", fr[0]); end
    ph = 16'h0200; mag = MAG_LO; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_reset(1);
    n = 0;
    repeat (20) begin @(negedge clk); if (sqo != 2'b00 || ov != 2'b00) n++; end
    cmp_cnt++; if (n != 0) begin err_cnt++; $display("FAIL hold after reset capture cycles got %0d want 0", n); end
    mag_rdy = 1'b0;
    @(negedge clk);
    send(16'h0200, MAG_LO, 1, 1);
    cmp_cnt++; if (sqo !== 2'b11) begin err_cnt++; $display("FAIL hold new edge sq got %b want 11", sqo); end
  endtask

  task automatic test_random();
    logic [W-1:0] p;
    logic [XW-1:0] m;
    bit rb, rk;
    do_clr();
    repeat (150) begin
      p  = W'(int'($urandom_range(0, 'h7FFF)) - 'h3FFF);
      m  = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 'hFF)) : XW'($urandom_range('h100, 'h3FFF));
      rb = ($urandom_range(0, 3) != 0);
      rk = ($urandom_range(0, 3) != 0);
      send(p, m, rb, rk);
      for (int i = 0; i < 2; i++) begin
        cmp_cnt++; if (ov[i] !== m_vld[i]) begin err_cnt++; $display("FAIL rand out_valid[%0d] got %b want %b", i, ov[i], m_vld[i]); end
        cmp_cnt++; if (fr[i] !== m_freq[i]) begin err_cnt++; $display("FAIL rand freq[%0d] got %h want %h", i, fr[i], m_freq[i]); end
        cmp_cnt++; if (sqo[i] !== m_sq[i]) begin err_cnt++; $display("FAIL rand sq[%0d] got %b want %b", i, sqo[i], m_sq[i]); end
        cmp_cnt++; if (ovo[i] !== m_ovf[i]) begin err_cnt++; $display("FAIL rand ovf[%0d] got %b want %b", i, ovo[i], m_ovf[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; mag_rdy = 1'b0; out_ready = 1'b1;
    ph = '0; mag = '0; thr = THR;
    m_reset(1);
    test_reset();
    test_basic();
    test_wrap();
    test_squelch();
    test_avg();
    test_backpressure();
    test_reset_abort();
    test_level_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
